// File: rtl/io_capture_pkg.sv
// rtl/io_capture_pkg.sv - shared constants for the output-port capture slice
package io_capture_pkg;

   localparam int         DATA_W_DEF = 8;
   localparam int         DEPTH_DEF  = 8;
   localparam logic [7:0] DROP_MAX   = 8'hFF;

   typedef enum logic [1:0] {
      FIFO_IDLE = 2'b00,
      FIFO_POP  = 2'b01,
      FIFO_PUSH = 2'b10,
      FIFO_BOTH = 2'b11
   } fifo_op_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == DROP_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/out_port_capture_if.sv
// rtl/out_port_capture_if.sv - valid/ready drain port for captured output values
interface out_port_capture_if
   import io_capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;

   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; head read from memory at registered rd_ptr
module sync_fifo
   import io_capture_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W     = DATA_W_DEF,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;
   fifo_op_e      op;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign op      = fifo_op_e'({do_push, do_pop});

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      case (op)
         FIFO_PUSH: begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
         end
         FIFO_POP: begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
         end
         FIFO_BOTH: begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/out_port_capture.sv
// rtl/out_port_capture.sv - records every change of the processor output port into a drainable FIFO
// with sticky halt/overflow flags and a saturating dropped-value count.
module out_port_capture
   import io_capture_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_W-1:0]      out_port,
   input  logic                   hlt,
   out_port_capture_if.master     m,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic [7:0]             drop_cnt,
   output logic                   halted
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] prev_q;
   logic              halted_q, halted_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;

   logic              change;
   logic              pop;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rdata;
   logic [CW-1:0]     fifo_count;

   // The halt latch gates capture only from the cycle after hlt is seen.
   assign change = (out_port != prev_q) && !halted_q;
   assign pop    = !fifo_empty && m.m_ready;
   assign drop   = change && fifo_full && !pop;

   sync_fifo #(
      .DEPTH (DEPTH),
      .W     (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (change),
      .pop_i   (pop),
      .wdata_i (out_port),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      halted_d   = halted_q | hlt;
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop ? sat_inc8(drop_cnt_q) : drop_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= '0;
         halted_q   <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         prev_q     <= out_port;
         halted_q   <= halted_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign m.m_valid = !fifo_empty;
   assign m.m_data  = fifo_rdata;
   assign count     = fifo_count;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_out_port_capture.sv
// tb/tb_out_port_capture.sv - directed scoreboard bench for out_port_capture
module tb_out_port_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] out_port;
   logic       hlt;
   logic [3:0] count;
   logic       overflow;
   logic [7:0] drop_cnt;
   logic       halted;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_q [$];

   out_port_capture_if #(.DATA_W(8)) bus ();

   out_port_capture #(.DEPTH(8), .DATA_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .out_port (out_port),
      .hlt      (hlt),
      .m        (bus),
      .count    (count),
      .overflow (overflow),
      .drop_cnt (drop_cnt),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drain(input string tag);
      int budget = 0;
      bus.m_ready = 1'b1;
      while (exp_q.size() > 0 && budget < 64) begin
         if (bus.m_valid === 1'b1) check(tag, bus.m_data, exp_q.pop_front());
         tick();
         budget++;
      end
      bus.m_ready = 1'b0;
      check({tag, "_left"}, exp_q.size(), 0);
      check({tag, "_valid_after"}, bus.m_valid, 1'b0);
   endtask

   task automatic drive_change(input logic [7:0] v, input int hold, input bit expect_push);
      out_port = v;
      if (expect_push) exp_q.push_back(v);
      repeat (hold) tick();
   endtask

   initial begin
      rst = 1'b1;
      out_port = 8'h00;
      hlt = 1'b0;
      bus.m_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset then idle at 00
      repeat (10) tick();
      check("idle_valid", bus.m_valid, 1'b0);
      check("idle_count", count, 0);
      check("idle_overflow", overflow, 1'b0);
      check("idle_drop", drop_cnt, 0);
      check("idle_halted", halted, 1'b0);

      // latency: first change visible one edge later
      out_port = 8'h0C;
      exp_q.push_back(8'h0C);
      tick();
      check("latency_valid", bus.m_valid, 1'b1);
      check("latency_data", bus.m_data, 8'h0C);
      tick();
      tick();
      drive_change(8'h2D, 3, 1'b1);
      drive_change(8'h17, 3, 1'b1);
      drive_change(8'h43, 3, 1'b1);
      drive_change(8'h22, 3, 1'b1);
      check("seq_count", count, 5);
      drain("seq_drain");

      // 10 distinct values into an 8-deep FIFO
      for (int i = 0; i < 10; i++) drive_change(8'h81 + 8'(i), 1, i < 8);
      check("ovf_count", count, 8);
      check("ovf_flag", overflow, 1'b1);
      check("ovf_drop", drop_cnt, 2);

      // full FIFO, new value with simultaneous pop
      check("fullpop_head", bus.m_data, exp_q.pop_front());
      out_port = 8'h55;
      bus.m_ready = 1'b1;
      exp_q.push_back(8'h55);
      tick();
      bus.m_ready = 1'b0;
      check("fullpop_count", count, 8);
      check("fullpop_overflow", overflow, 1'b1);
      check("fullpop_drop", drop_cnt, 2);
      drain("ovf_drain");

      // reset with entries queued, then a fresh capture
      drive_change(8'h11, 1, 1'b0);
      drive_change(8'h12, 1, 1'b0);
      drive_change(8'h13, 1, 1'b0);
      check("prerst_count", count, 3);
      rst = 1'b1;
      out_port = 8'h00;
      tick();
      rst = 1'b0;
      check("rst_count", count, 0);
      check("rst_valid", bus.m_valid, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_drop", drop_cnt, 0);
      drive_change(8'h07, 2, 1'b1);
      check("post_rst_count", count, 1);
      drain("post_rst_drain");

      // halt: change in the halt cycle is kept, later changes are not
      out_port = 8'h43;
      hlt = 1'b1;
      exp_q.push_back(8'h43);
      tick();
      hlt = 1'b0;
      out_port = 8'h99;
      tick();
      tick();
      out_port = 8'h5A;
      tick();
      check("halt_flag", halted, 1'b1);
      check("halt_count", count, 1);
      drain("halt_drain");

      rst = 1'b1;
      out_port = 8'h00;
      tick();
      rst = 1'b0;
      check("halt_rst_flag", halted, 1'b0);

      // drop counter saturation
      for (int i = 0; i < 270; i++) begin
         out_port = 8'(i + 1);
         tick();
      end
      check("sat_count", count, 8);
      check("sat_drop", drop_cnt, 8'hFF);
      check("sat_overflow", overflow, 1'b1);

      // reset in the middle of a drain
      bus.m_ready = 1'b1;
      tick();
      tick();
      check("middrain_count", count, 6);
      rst = 1'b1;
      out_port = 8'h00;
      tick();
      rst = 1'b0;
      bus.m_ready = 1'b0;
      tick();
      check("middrain_rst_count", count, 0);
      check("middrain_rst_valid", bus.m_valid, 1'b0);
      check("middrain_rst_drop", drop_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/out_port_capture.md
# out_port_capture

Capture block on the processor's output side. It watches the 8-bit `Out_port` and `HLT` outputs of `top` and detects every change of `Out_port`. Each change is queued in a small FIFO, which a host or bench drains with a valid/ready handshake. It also records a sticky halt flag, an overflow flag and a dropped-value count, so a program's full output history can be checked after it runs.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `DATA_W`, 8: width of the captured value; matches `Out_port`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `out_port`  in  DATA_W  processor `Out_port`.
- `hlt`  in  1  processor `HLT` flag.
- `m_valid`  out  1  FIFO head holds a value.
- `m_ready`  in  1  consumer accepts the head this cycle.
- `m_data`  out  DATA_W  FIFO head value; defined only while `m_valid`=1.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; set when a change was dropped.
- `drop_cnt`  out  8  number of dropped changes; saturates at 255.
- `halted`  out  1  sticky; `hlt` has been seen high.

## Operation
- `prev` register holds the last sampled `out_port`; reset value 8'h00.
- A change is flagged in a cycle when `out_port != prev` and `halted`=0. `prev` loads `out_port` every cycle.
- Push: a flagged change writes `out_port` at `wr_ptr` if the FIFO is not full, or if it is full and a pop happens in the same cycle.
- Drop: a flagged change with the FIFO full and no pop. The value is discarded, `overflow` is set to 1 and `drop_cnt` increments, saturating at 8'hFF. `prev` still updates.
- Pop: `m_valid && m_ready` advances `rd_ptr`. `m_ready` with an empty FIFO has no effect.
- Simultaneous push and pop: both happen and `count` is unchanged, including when the FIFO is full or holds one entry.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full means `count`==DEPTH; empty means `count`==0.
- Halt: when `hlt`=1 is sampled, `halted` is set. A change flagged in the same cycle is still pushed. From the next cycle on, no further changes are captured. Pops continue normally.
- `rst` clears pointers, `count`, `prev`, `overflow`, `drop_cnt` and `halted`, and discards FIFO contents. It takes priority over push and pop in the same cycle, including in the middle of a drain.

## Timing
- Reset values: `m_valid`=0, `count`=0, `overflow`=0, `drop_cnt`=0, `halted`=0, `m_data` don't-care.
- Latency: a value that differs from `prev` at rising edge k is visible on `m_data` with `m_valid`=1 after edge k (one cycle) when the FIFO was empty.
- `m_valid` and `m_data` come from registers or memory with a registered `rd_ptr`; there is no combinational path from `out_port` or `m_ready` to the outputs.
- `m_data` stays stable while `m_valid`=1 and `m_ready`=0.
- A value held for several cycles produces exactly one entry. A→B→A produces three entries.
- `out_port` equal to 8'h00 right after reset produces no entry.

## Structure
- Shared package `io_capture_pkg` holds `DATA_W_DEF`=8, `DEPTH_DEF`=8 and `DROP_MAX`=8'hFF.
- One sub-module, `sync_fifo`: a parameterised single-clock FIFO with push/pop, `count`, full and empty.
- Change detection, halt latch and drop statistics stay in `out_port_capture`.

## Test plan
- Reset then idle: `out_port`=00 for 10 cycles -> `m_valid`=0, `count`=0, all flags 0.
- Sequence 0C, 2D, 17, 43, 22, each held 3 cycles, with `m_ready`=0 -> `count`=5. Draining with `m_ready`=1 yields 0C, 2D, 17, 43, 22 in order, then `m_valid`=0.
- DEPTH=8 with 10 distinct values and no pops -> `count`=8, `overflow`=1, `drop_cnt`=2. The drain returns the first 8 values.
- FIFO full with a new value 55 and `m_ready`=1 in the same cycle -> head pops, 55 is queued, `count` stays 8, `overflow` unchanged.
- `out_port`=43 in the same cycle `hlt` rises, then `out_port`=99 -> queue holds 43 only, `halted`=1.
- `rst` pulsed for 1 cycle with 3 entries queued -> next cycle `count`=0, `m_valid`=0, `halted`=0. A following change to 07 is captured.
